// File: rtl/eit_scan_sequencer.sv
// EIT adjacent-drive / adjacent-measure frame sequencer feeding mux_controller.
// Each frame steps drive d and sense offset k, handshaking with the mux and the ADC.
module eit_scan_sequencer #(
  parameter int N_ELEC        = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int MUX_TIMEOUT   = 1024,
  parameter int ADC_TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       abort,
  output logic [7:0] mux_val,
  output logic       start_mux,
  input  logic       mux_done,
  output logic       adc_start,
  input  logic       adc_done,
  output logic [7:0] meas_index,
  output logic       busy,
  output logic       frame_done,
  output logic       error
);

  // Handshake: start_mux / adc_start are one-cycle requests issued from the REQ
  // states; the matching done is honoured only while sitting in the WAIT state.

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUX_REQ,
    S_MUX_WAIT,
    S_SETTLE,
    S_ADC_REQ,
    S_ADC_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int CNT_MAX_A = (MUX_TIMEOUT > ADC_TIMEOUT) ? MUX_TIMEOUT : ADC_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > SETTLE_CYCLES) ? CNT_MAX_A : SETTLE_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] MUX_LAST    = CW'(MUX_TIMEOUT - 1);
  localparam logic [CW-1:0] ADC_LAST    = CW'(ADC_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  localparam logic [3:0] K_FIRST = 4'd2;
  localparam logic [3:0] K_LAST  = 4'(N_ELEC - 2);
  localparam logic [3:0] D_LAST  = 4'(N_ELEC - 1);
  localparam logic [4:0] N_MOD   = 5'(N_ELEC);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    drive;
  logic [3:0]    offset;
  logic [3:0]    drive_nxt;
  logic [3:0]    offset_nxt;
  logic [4:0]    sense_sum;
  logic [3:0]    sense_nxt;
  logic          load_val;
  logic          meas_clr;
  logic          meas_inc;
  logic          err_set;
  logic          err_clr;

  always_comb begin
    state_nxt  = state;
    drive_nxt  = drive;
    offset_nxt = offset;
    load_val   = 1'b0;
    meas_clr   = 1'b0;
    meas_inc   = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state_nxt  = S_MUX_REQ;
            drive_nxt  = 4'd0;
            offset_nxt = K_FIRST;
            load_val   = 1'b1;
            meas_clr   = 1'b1;
            err_clr    = 1'b1;
          end
        end
        S_MUX_REQ: state_nxt = S_MUX_WAIT;
        S_MUX_WAIT: begin
          // A done arriving on the final allowed cycle still counts.
          if (mux_done) begin
            state_nxt = S_SETTLE;
          end else if (cnt == MUX_LAST) begin
            state_nxt = S_IDLE;
            err_set   = 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) state_nxt = S_ADC_REQ;
        end
        S_ADC_REQ: state_nxt = S_ADC_WAIT;
        S_ADC_WAIT: begin
          if (adc_done) begin
            state_nxt = S_NEXT;
          end else if (cnt == ADC_LAST) begin
            state_nxt = S_IDLE;
            err_set   = 1'b1;
          end
        end
        S_NEXT: begin
          if (offset < K_LAST) begin
            state_nxt  = S_MUX_REQ;
            offset_nxt = offset + 4'd1;
            load_val   = 1'b1;
            meas_inc   = 1'b1;
          end else if (drive < D_LAST) begin
            state_nxt  = S_MUX_REQ;
            drive_nxt  = drive + 4'd1;
            offset_nxt = K_FIRST;
            load_val   = 1'b1;
            meas_inc   = 1'b1;
          end else begin
            state_nxt = S_DONE;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Sense electrode for the upcoming measurement; modulo by conditional subtract.
  always_comb begin
    sense_sum = {1'b0, drive_nxt} + {1'b0, offset_nxt};
    sense_nxt = (sense_sum >= N_MOD) ? 4'(sense_sum - N_MOD) : sense_sum[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      drive      <= 4'd0;
      offset     <= K_FIRST;
      mux_val    <= 8'h00;
      meas_index <= 8'h00;
      error      <= 1'b0;
    end else begin
      state <= state_nxt;
      // Dwell counter restarts on every state change.
      if (state_nxt != state || state == S_IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      drive  <= drive_nxt;
      offset <= offset_nxt;
      if (load_val) begin
        mux_val <= {sense_nxt, drive_nxt};
      end
      if (meas_clr) begin
        meas_index <= 8'h00;
      end else if (meas_inc) begin
        meas_index <= meas_index + 8'd1;
      end
      if (err_set) begin
        error <= 1'b1;
      end else if (err_clr) begin
        error <= 1'b0;
      end
    end
  end

  assign start_mux  = (state == S_MUX_REQ);
  assign adc_start  = (state == S_ADC_REQ);
  assign frame_done = (state == S_DONE);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_eit_scan_sequencer.sv
// Directed bench for eit_scan_sequencer: N=16 and N=8 instances with
// 3-cycle mux/ADC responders and per-scenario checking tasks.
module tb_eit_scan_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // N=16 instance
  logic       frame_start = 1'b0;
  logic       abort = 1'b0;
  logic       mux_done_r = 1'b0;
  logic       mux_done_i = 1'b0;
  logic       adc_done_r = 1'b0;
  logic       adc_done_i = 1'b0;
  logic       mux_resp_en = 1'b1;
  logic [7:0] mux_val;
  logic       start_mux;
  logic       adc_start;
  logic [7:0] meas_index;
  logic       busy;
  logic       frame_done;
  logic       error;

  eit_scan_sequencer #(
    .N_ELEC(16), .SETTLE_CYCLES(8), .MUX_TIMEOUT(100), .ADC_TIMEOUT(1024)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .abort(abort),
    .mux_val(mux_val), .start_mux(start_mux), .mux_done(mux_done_r | mux_done_i),
    .adc_start(adc_start), .adc_done(adc_done_r | adc_done_i),
    .meas_index(meas_index), .busy(busy), .frame_done(frame_done), .error(error)
  );

  // N=8 instance
  logic       fs8 = 1'b0;
  logic       abort8 = 1'b0;
  logic       md8_r = 1'b0;
  logic       ad8_r = 1'b0;
  logic [7:0] mv8;
  logic       sm8;
  logic       as8;
  logic [7:0] mi8;
  logic       busy8;
  logic       fd8;
  logic       err8;

  eit_scan_sequencer #(
    .N_ELEC(8), .SETTLE_CYCLES(8), .MUX_TIMEOUT(1024), .ADC_TIMEOUT(1024)
  ) dut8 (
    .clk(clk), .rst(rst), .frame_start(fs8), .abort(abort8),
    .mux_val(mv8), .start_mux(sm8), .mux_done(md8_r),
    .adc_start(as8), .adc_done(ad8_r),
    .meas_index(mi8), .busy(busy8), .frame_done(fd8), .error(err8)
  );

  // Responders: done asserted for one cycle, 3 cycles after the strobe.
  always begin
    @(negedge clk);
    if (start_mux && mux_resp_en) begin
      repeat (3) @(negedge clk);
      mux_done_r = 1'b1;
      @(negedge clk);
      mux_done_r = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    if (adc_start) begin
      repeat (3) @(negedge clk);
      adc_done_r = 1'b1;
      @(negedge clk);
      adc_done_r = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    if (sm8) begin
      repeat (3) @(negedge clk);
      md8_r = 1'b1;
      @(negedge clk);
      md8_r = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    if (as8) begin
      repeat (3) @(negedge clk);
      ad8_r = 1'b1;
      @(negedge clk);
      ad8_r = 1'b0;
    end
  end

  // Monitors
  int         n_sm = 0;
  int         n_as = 0;
  int         n_fd = 0;
  int         settle_bad = 0;
  int         last_mdr = -100;
  logic [7:0] obs_q[$];
  int         n_sm8 = 0;
  int         n_fd8 = 0;
  logic [7:0] obs8_q[$];

  always begin
    @(negedge clk);
    #1;
    if (mux_done_r) last_mdr = cyc;
    if (start_mux) begin
      n_sm = n_sm + 1;
      obs_q.push_back(mux_val);
    end
    if (adc_start) begin
      n_as = n_as + 1;
      if (cyc - last_mdr != 9) settle_bad = settle_bad + 1;
    end
    if (frame_done) n_fd = n_fd + 1;
    if (sm8) begin
      n_sm8 = n_sm8 + 1;
      obs8_q.push_back(mv8);
    end
    if (fd8) n_fd8 = n_fd8 + 1;
  end

  // Reference scan order: measurement idx -> {sense, drive}.
  function automatic logic [7:0] exp_val(input int n, input int idx);
    int d;
    int k;
    int s;
    d = idx / (n - 3);
    k = 2 + (idx % (n - 3));
    s = (d + k) % n;
    return 8'((s * 16) + d);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mux_val, start_mux, adc_start, meas_index, busy, frame_done, error} !== 21'h0) begin
      errors++;
      $display("FAIL reset_outputs16: got %h expected 000000", {mux_val, start_mux, adc_start, meas_index, busy, frame_done, error});
    end
    checks++;
    if ({mv8, sm8, as8, mi8, busy8, fd8, err8} !== 21'h0) begin
      errors++;
      $display("FAIL reset_outputs8: got %h expected 000000", {mv8, sm8, as8, mi8, busy8, fd8, err8});
    end
    rst = 1'b0;
    @(negedge clk);
    mux_done_i = 1'b1;
    adc_done_i = 1'b1;
    @(negedge clk);
    mux_done_i = 1'b0;
    adc_done_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, start_mux, adc_start} !== 3'b000) begin
      errors++;
      $display("FAIL idle_done_ignored: busy/start/adc got %b expected 000", {busy, start_mux, adc_start});
    end
  endtask

  task automatic test_full_frame();
    int         f;
    int         fd_c = 0;
    int         sm_c;
    int         base;
    int         b_sm;
    int         b_as;
    int         b_fd;
    int         b_sb;
    int         bad = 0;
    logic       seen = 1'b0;
    logic       fd_busy = 1'b0;
    logic [7:0] fd_mi = 8'h00;
    logic [7:0] exp_q[$];
    base = obs_q.size();
    b_sm = n_sm;
    b_as = n_as;
    b_fd = n_fd;
    b_sb = settle_bad;
    @(negedge clk);
    frame_start = 1'b1;
    f = cyc;
    @(negedge clk);
    frame_start = 1'b0;
    sm_c = cyc;
    checks++;
    if ({start_mux, busy, mux_val, meas_index} !== {1'b1, 1'b1, 8'h20, 8'h00}) begin
      errors++;
      $display("FAIL frame_start_latency: start/busy/mux_val/meas got %h expected 32000", {start_mux, busy, mux_val, meas_index});
    end
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        fd_c = cyc;
        fd_mi = meas_index;
        fd_busy = busy;
      end else begin
        if (start_mux) sm_c = cyc;
        mux_done_i = (start_mux && meas_index == 8'd5) || (meas_index == 8'd6 && cyc == sm_c + 6);
        adc_done_i = (adc_start && meas_index == 8'd7) || (meas_index == 8'd6 && cyc == sm_c + 6);
        frame_start = start_mux && (meas_index == 8'd100);
      end
    end
    mux_done_i = 1'b0;
    adc_done_i = 1'b0;
    frame_start = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL full_frame_timeout: frame_done got 0 expected 1 within 5000 cycles");
    end
    checks++;
    if (fd_c - f != 3537) begin
      errors++;
      $display("FAIL frame_done_cycle: got %0d expected 3537", fd_c - f);
    end
    checks++;
    if ({fd_busy, fd_mi} !== {1'b1, 8'd207}) begin
      errors++;
      $display("FAIL frame_end_state: busy/meas got %h expected 1cf", {fd_busy, fd_mi});
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, error} !== 2'b00) begin
      errors++;
      $display("FAIL post_frame_idle: busy/error got %b expected 00", {busy, error});
    end
    checks++;
    if (n_sm - b_sm != 208 || n_as - b_as != 208) begin
      errors++;
      $display("FAIL strobe_counts: start_mux %0d adc_start %0d expected 208 208", n_sm - b_sm, n_as - b_as);
    end
    checks++;
    if (n_fd - b_fd != 1) begin
      errors++;
      $display("FAIL frame_done_count: got %0d expected 1", n_fd - b_fd);
    end
    checks++;
    if (settle_bad != b_sb) begin
      errors++;
      $display("FAIL settle_gap: got %0d bad gaps expected 0", settle_bad - b_sb);
    end
    for (int i = 0; i < 208; i++) exp_q.push_back(exp_val(16, i));
    checks++;
    if (obs_q.size() - base != 208) begin
      errors++;
      $display("FAIL mux_val_count: got %0d expected 208", obs_q.size() - base);
    end else begin
      for (int i = 0; i < 208; i++) begin
        if (obs_q[base + i] !== exp_q[i]) bad++;
      end
      if (bad != 0) begin
        errors++;
        $display("FAIL mux_val_sequence: got %0d wrong values expected 0", bad);
      end
      checks++;
      if ({obs_q[base], obs_q[base + 1], obs_q[base + 12], obs_q[base + 13], obs_q[base + 207]} !== 40'h2030E031DF) begin
        errors++;
        $display("FAIL mux_val_landmarks: got %h expected 2030e031df", {obs_q[base], obs_q[base + 1], obs_q[base + 12], obs_q[base + 13], obs_q[base + 207]});
      end
    end
  endtask

  task automatic test_abort();
    int   b_fd;
    logic found = 1'b0;
    b_fd = n_fd;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (adc_start && meas_index == 8'd50) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_reach_meas50: got 0 expected 1");
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, start_mux, adc_start, frame_done, error, mux_val} !== {5'b00000, 8'h03}) begin
      errors++;
      $display("FAIL abort_idle: busy/start/adc/done/err/mux_val got %h expected 0003", {busy, start_mux, adc_start, frame_done, error, mux_val});
    end
    repeat (20) @(negedge clk);
    checks++;
    if (n_fd - b_fd != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_frame_done: frame_done %0d busy %b expected 0 0", n_fd - b_fd, busy);
    end
    abort = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    frame_start = 1'b0;
    checks++;
    if ({busy, start_mux} !== 2'b00) begin
      errors++;
      $display("FAIL abort_beats_start: busy/start got %b expected 00", {busy, start_mux});
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checks++;
    if ({start_mux, busy, mux_val, meas_index} !== {1'b1, 1'b1, 8'h20, 8'h00}) begin
      errors++;
      $display("FAIL restart_after_abort: start/busy/mux_val/meas got %h expected 32000", {start_mux, busy, mux_val, meas_index});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_timeout();
    int b_as;
    b_as = n_as;
    mux_resp_en = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if ({busy, error} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_early: busy/error got %b expected 10", {busy, error});
    end
    @(negedge clk);
    checks++;
    if ({busy, error} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_fire: busy/error got %b expected 01", {busy, error});
    end
    checks++;
    if (n_as - b_as != 0) begin
      errors++;
      $display("FAIL timeout_no_adc: got %0d adc_start expected 0", n_as - b_as);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL abort_keeps_error: got %b expected 1", error);
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checks++;
    if ({busy, error} !== 2'b10) begin
      errors++;
      $display("FAIL start_clears_error: busy/error got %b expected 10", {busy, error});
    end
    repeat (101) @(negedge clk);
    checks++;
    if ({busy, error} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_second: busy/error got %b expected 01", {busy, error});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, error} !== 2'b00) begin
      errors++;
      $display("FAIL reset_clears_error: busy/error got %b expected 00", {busy, error});
    end
    mux_resp_en = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_settle();
    int   b_as;
    logic found = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (start_mux && meas_index == 8'd3) found = 1'b1;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (!found || {busy, mux_val, meas_index} !== {1'b1, 8'h50, 8'd3}) begin
      errors++;
      $display("FAIL settle_precondition: busy/mux_val/meas got %h expected 15003", {busy, mux_val, meas_index});
    end
    b_as = n_as;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({mux_val, start_mux, adc_start, meas_index, busy, frame_done, error} !== 21'h0) begin
      errors++;
      $display("FAIL reset_mid_settle: got %h expected 000000", {mux_val, start_mux, adc_start, meas_index, busy, frame_done, error});
    end
    repeat (20) @(negedge clk);
    checks++;
    if (n_as - b_as != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_stays_idle: adc_start %0d busy %b expected 0 0", n_as - b_as, busy);
    end
  endtask

  task automatic test_n8();
    int         f;
    int         fd_c = 0;
    int         base;
    int         b_sm;
    int         b_fd;
    int         bad = 0;
    logic       seen = 1'b0;
    logic [7:0] fd_mi = 8'h00;
    logic [7:0] exp_q[$];
    base = obs8_q.size();
    b_sm = n_sm8;
    b_fd = n_fd8;
    @(negedge clk);
    fs8 = 1'b1;
    f = cyc;
    @(negedge clk);
    fs8 = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (fd8) begin
        seen = 1'b1;
        fd_c = cyc;
        fd_mi = mi8;
      end
    end
    checks++;
    if (!seen || fd_c - f != 681) begin
      errors++;
      $display("FAIL n8_frame_done_cycle: got %0d expected 681", fd_c - f);
    end
    checks++;
    if (fd_mi !== 8'd39) begin
      errors++;
      $display("FAIL n8_last_index: got %0d expected 39", fd_mi);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_sm8 - b_sm != 40 || n_fd8 - b_fd != 1) begin
      errors++;
      $display("FAIL n8_counts: start_mux %0d frame_done %0d expected 40 1", n_sm8 - b_sm, n_fd8 - b_fd);
    end
    for (int i = 0; i < 40; i++) exp_q.push_back(exp_val(8, i));
    checks++;
    if (obs8_q.size() - base != 40) begin
      errors++;
      $display("FAIL n8_mux_val_count: got %0d expected 40", obs8_q.size() - base);
    end else begin
      for (int i = 0; i < 40; i++) begin
        if (obs8_q[base + i] !== exp_q[i]) bad++;
      end
      if (bad != 0) begin
        errors++;
        $display("FAIL n8_mux_val_sequence: got %0d wrong values expected 0", bad);
      end
      checks++;
      if (obs8_q[base + 39] !== 8'h57) begin
        errors++;
        $display("FAIL n8_last_mux_val: got %h expected 57", obs8_q[base + 39]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_abort();
    test_timeout();
    test_reset_mid_settle();
    test_n8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
